// File: rtl/timer_gen_if.sv
// Control/status bundle between a sequencing controller (master) and timer_gen (slave).
interface timer_gen_if #(
    parameter int WIDTH = 16,
    parameter int PW    = 8
);
    logic             t_en;
    logic             t_clr;
    logic [1:0]       t_mode;
    logic [WIDTH-1:0] t_limit;
    logic [PW-1:0]    t_presc;
    logic [WIDTH-1:0] t_out;
    logic             t_valid;
    logic             t_done;

    modport master (
        output t_en, t_clr, t_mode, t_limit, t_presc,
        input  t_out, t_valid, t_done
    );

    modport slave (
        input  t_en, t_clr, t_mode, t_limit, t_presc,
        output t_out, t_valid, t_done
    );
endinterface

// File: rtl/timer_gen.sv
// Parametrised timer with prescaler, four counting modes, pause/clear and a
// one-cycle terminal-count pulse. Configuration is latched only on start.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | stopped, outputs zero, waiting for t_en to start
//   RUN   | counting on prescaler ticks while t_en is high, frozen when low
//   DONE  | one-shot finished, count holds limit until t_clr / rst
module timer_gen #(
    parameter int WIDTH = 16,
    parameter int PW    = 8
) (
    input  logic         clk,
    input  logic         rst,
    timer_gen_if.slave   tif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] M_FREE     = 2'b00;
    localparam logic [1:0] M_ONESHOT  = 2'b01;
    localparam logic [1:0] M_PERIODIC = 2'b10;
    localparam logic [1:0] M_DOWN     = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    // State register and all datapath flops, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            mode_q  <= '0;
            limit_q <= '0;
            presc_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
            presc_q <= presc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state, prescaler, count step and terminal-count detection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        mode_d  = mode_q;
        limit_d = limit_q;
        presc_d = presc_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        if (tif.t_clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            pre_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    pre_d = '0;
                    if (tif.t_en) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                        mode_d  = tif.t_mode;
                        limit_d = tif.t_limit;
                        presc_d = tif.t_presc;
                        cnt_d   = (tif.t_mode == M_DOWN) ? tif.t_limit : '0;
                    end
                end
                RUN: begin
                    if (tif.t_en) begin
                        if (pre_q != presc_q) begin
                            pre_d = pre_q + PW'(1);
                        end else begin
                            // Tick: the prescaler restarts and the count steps.
                            pre_d = '0;
                            unique case (mode_q)
                                M_FREE: begin
                                    cnt_d  = cnt_q + WIDTH'(1);
                                    done_d = (cnt_q == {WIDTH{1'b1}});
                                end
                                M_PERIODIC: begin
                                    done_d = (cnt_q == limit_q);
                                    cnt_d  = done_d ? '0 : cnt_q + WIDTH'(1);
                                end
                                M_DOWN: begin
                                    done_d = (cnt_q == '0);
                                    cnt_d  = done_d ? limit_q : cnt_q - WIDTH'(1);
                                end
                                M_ONESHOT: begin
                                    done_d = (cnt_q == limit_q);
                                    if (done_d) state_d = DONE;
                                    else        cnt_d = cnt_q + WIDTH'(1);
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                DONE: ;
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pre_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign tif.t_out   = cnt_q;
    assign tif.t_valid = valid_q;
    assign tif.t_done  = done_q;
endmodule

// File: tb/tb_timer_gen.sv
// Randomised + directed bench for timer_gen. A tick-count reference model
// pushes expected outputs into a scoreboard; a monitor pops and compares.
module tb_timer_gen;
    localparam int W  = 4;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timer_gen_if #(.WIDTH(W), .PW(PW)) tif ();
    timer_gen #(.WIDTH(W), .PW(PW)) dut (.clk(clk), .rst(rst), .tif(tif));

    typedef struct {
        int out;
        int valid;
        int done;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_no  = 0;

    // staged configuration, driven onto the interface by apply()
    int cfg_mode = 0, cfg_lim = 0, cfg_p = 0;

    // reference model: a running count of enabled cycles since start
    bit     m_active = 0;
    int     m_mode, m_lim, m_p;
    longint m_cyc;

    function automatic int model_out();
        longint t;
        longint period;
        t = m_cyc / (m_p + 1);
        period = m_lim + 1;
        if (!m_active) return 0;
        case (m_mode)
            0: return int'(t % (1 << W));
            1: return int'((t > m_lim) ? m_lim : t);
            2: return int'(t % period);
            default: return int'(m_lim - (t % period));
        endcase
    endfunction

    task automatic apply(input bit r, input bit c, input bit en);
        exp_t   e;
        longint t;
        @(negedge clk);
        rst         = r;
        tif.t_clr   = c;
        tif.t_en    = en;
        tif.t_mode  = 2'(cfg_mode);
        tif.t_limit = W'(cfg_lim);
        tif.t_presc = PW'(cfg_p);
        e.done = 0;
        if (r || c) begin
            m_active = 0;
        end else if (!m_active) begin
            if (en) begin
                m_active = 1;
                m_mode = cfg_mode; m_lim = cfg_lim; m_p = cfg_p;
                m_cyc = 0;
            end
        end else if (en && !(m_mode == 1 && m_cyc / (m_p + 1) > m_lim)) begin
            m_cyc++;
            if (m_cyc % (m_p + 1) == 0) begin
                t = m_cyc / (m_p + 1);
                case (m_mode)
                    0: e.done = (t % (1 << W) == 0);
                    1: e.done = (t == m_lim + 1);
                    default: e.done = (t % (m_lim + 1) == 0);
                endcase
            end
        end
        e.out   = model_out();
        e.valid = m_active;
        e.idx   = step_no++;
        sb.push_back(e);
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) apply(0, 0, en);
    endtask

    task automatic start(input int mode, input int lim, input int p);
        cfg_mode = mode; cfg_lim = lim; cfg_p = p;
        apply(0, 1, 0);
        apply(0, 0, 1);
    endtask

    // monitor: compare each expected entry one step after its clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks += 3;
                if (int'(tif.t_out) != e.out) begin
                    n_errors++;
                    $display("FAIL t_out step %0d: got %0d expected %0d", e.idx, tif.t_out, e.out);
                end
                if (int'(tif.t_valid) != e.valid) begin
                    n_errors++;
                    $display("FAIL t_valid step %0d: got %0d expected %0d", e.idx, tif.t_valid, e.valid);
                end
                if (int'(tif.t_done) != e.done) begin
                    n_errors++;
                    $display("FAIL t_done step %0d: got %0d expected %0d", e.idx, tif.t_done, e.done);
                end
            end
        end
    end

    initial begin
        tif.t_en = 0; tif.t_clr = 0; tif.t_mode = 0; tif.t_limit = 0; tif.t_presc = 0;

        // reset then idle
        apply(1, 0, 0);
        run(5, 0);

        // FREE, presc 0: 0..15 wrap with pulse
        start(0, 0, 0);
        run(20, 1);

        // PERIODIC limit 4 presc 2, limit change mid-run ignored
        start(2, 4, 2);
        run(20, 1);
        cfg_lim = 9; cfg_mode = 0; cfg_p = 0;
        run(25, 1);

        // ONESHOT limit 3, en toggling after DONE, then clear
        start(1, 3, 0);
        run(6, 1);
        run(2, 0);
        run(2, 1);
        apply(0, 1, 0);
        run(2, 0);

        // DOWN limit 2 with a 3-cycle pause at count 1
        start(3, 2, 0);
        run(1, 1);
        run(3, 0);
        run(8, 1);

        // clr beats en in RUN; rst mid-PERIODIC
        start(2, 4, 0);
        run(5, 1);
        apply(0, 1, 1);
        run(2, 0);
        start(2, 4, 0);
        run(4, 1);
        apply(1, 0, 1);
        run(2, 0);

        // limit 0 corner cases
        start(2, 0, 1); run(6, 1);
        start(3, 0, 0); run(4, 1);
        start(1, 0, 2); run(6, 1);

        // random segments, config inputs wiggled while running
        for (int s = 0; s < 40; s++) begin
            int n;
            if ($urandom_range(0, 4) == 0) apply(1, 0, 0);
            start($urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15),
                  $urandom_range(0, 3));
            n = $urandom_range(5, 60);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    cfg_mode = $urandom_range(0, 3);
                    cfg_lim  = $urandom_range(0, 15);
                    cfg_p    = $urandom_range(0, 7);
                end
                if ($urandom_range(0, 79) == 0)
                    apply(0, 1, $urandom_range(0, 1));
                else if ($urandom_range(0, 99) == 0)
                    apply(1, 0, 1);
                else
                    apply(0, 0, $urandom_range(0, 4) != 0);
            end
        end

        apply(0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/timer_gen.md
# timer_gen

Parametrised general-purpose timer, successor to the fixed 16-bit `timer`. It adds a configurable counter width, a clock prescaler, four counting modes (free-run, one-shot, periodic, down-count), pause/clear control and a terminal-count pulse. It sits beside the `timer` users in the system and is driven by a controller FSM through level-sensitive enable and clear inputs.

## Interface
- `WIDTH`, 16: counter width in bits (≥2)
- `PW`, 8: prescaler width in bits (≥1)

- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `t_en`  in  1  start (in IDLE) / run-enable (in RUN); low in RUN = pause
- `t_clr`  in  1  synchronous clear to IDLE; priority over `t_en`
- `t_mode`  in  2  00 FREE, 01 ONESHOT, 10 PERIODIC, 11 DOWN
- `t_limit`  in  WIDTH  terminal value for ONESHOT/PERIODIC, reload value for DOWN
- `t_presc`  in  PW  prescaler divide-minus-one (0 = tick every cycle)
- `t_out`  out  WIDTH  current count (registered)
- `t_valid`  out  1  high while in RUN or DONE (registered)
- `t_done`  out  1  one-cycle terminal-count pulse (registered)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `t_out`=0, `t_valid`=0, `t_done`=0. When `t_en`=1 and `t_clr`=0 → RUN. The same edge captures `t_mode`/`t_limit`/`t_presc` into shadow registers, sets prescaler `pre`=0 and count = shadow limit (DOWN) or 0 (other modes).
- Config inputs are ignored outside the IDLE→RUN edge. Changes during RUN/DONE take effect only on the next start.
- RUN, `t_en`=1: `pre` increments. A tick occurs on the edge where `pre`==shadow presc; that edge also resets `pre` to 0. On each tick, count steps: +1 in FREE/PERIODIC/ONESHOT, −1 in DOWN.
- RUN, `t_en`=0: `pre` and count frozen, `t_valid` stays 1, state unchanged.
- Terminal event is a tick while count equals the terminal value:
  - FREE: terminal = all-ones, wraps to 0.
  - PERIODIC: terminal = limit, reloads 0.
  - DOWN: terminal = 0, reloads limit.
  - ONESHOT: terminal = limit, count holds, → DONE.
- Every terminal event sets `t_done`=1 for exactly one cycle.
- DONE: `t_out` holds limit, `t_valid`=1, `t_en` ignored. Only `t_clr` or `rst` leaves, → IDLE.
- `t_clr`=1 in any state → IDLE on the next edge: `t_out`=0, `t_valid`=0, `t_done`=0, `pre`=0. `t_clr` and `t_en` both high → `t_clr` wins.
- Limit 0:
  - PERIODIC/DOWN: count stays 0 and `t_done` pulses on every tick.
  - ONESHOT: first tick → DONE.
- Count arithmetic is unsigned modulo 2^WIDTH. `pre` is PW-bit unsigned.

## Timing
- Reset (`rst`=1 at an edge): state IDLE, `t_out`=0, `t_valid`=0, `t_done`=0, `pre`=0, shadows 0. A mid-run `rst` has the same effect, with no pulse emitted.
- Start: `t_en` sampled high at edge k in IDLE → from after edge k, `t_valid`=1 and `t_out`=initial value.
- First tick is at edge k+1+presc; `t_out` shows the new value after that edge.
- `t_done` is high in the cycle after the terminal-tick edge, concurrent with the reloaded/held `t_out`.
- Period (PERIODIC/DOWN) = (limit+1)·(presc+1) cycles. FREE period = 2^WIDTH·(presc+1) cycles.
- ONESHOT: `t_done` asserted (limit+1)·(presc+1) cycles after the start edge.
- Pause latency: `t_en` low at edge j → no tick at edge j. Resume continues from the frozen `pre`.

## Test plan
- Reset/idle: `rst`=1 for 1 cycle, then `t_en`=0 for 5 cycles → `t_out`=0, `t_valid`=0, `t_done`=0 throughout.
- FREE, WIDTH=4, presc=0, `t_en`=1 for 20 cycles:
  - `t_out` runs 0,1,…,15,0,1,2,3.
  - `t_done` is high for one cycle, exactly when `t_out` first returns to 0 (16 cycles after start).
- PERIODIC, limit=4, presc=2:
  - `t_out` steps every 3 cycles through 0..4,0…
  - `t_done` pulses every 15 cycles.
  - Changing `t_limit` to 9 mid-run has no effect.
- ONESHOT, limit=3, presc=0:
  - `t_out` runs 0,1,2,3; `t_done` pulses once, 4 cycles after start; `t_out` then holds 3 with `t_valid`=1.
  - Toggling `t_en` has no effect.
  - `t_clr` → next cycle `t_out`=0, `t_valid`=0.
- DOWN, limit=2, presc=0, with `t_en` low for 3 cycles when `t_out`=1:
  - `t_out` is frozen at 1 during the pause, then continues 0,2,1,0,2.
  - `t_done` pulses with each reload to 2.
- Priority: `t_clr`=1 and `t_en`=1 together in RUN → IDLE (`t_out`=0). `rst`=1 mid-PERIODIC → all outputs 0 next cycle and no `t_done` pulse.
